imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the synchronous-read instruction memory. The memory is word-indexed, has 1-cycle read latency and no enable.
- Owns the fetch PC and drives the word index into the memory. Captures returned words into a 2-entry queue tagged with their PC, and presents them to decode over a valid/ready handshake.
- Handles decode stall, branch/jump redirect with flush, and an out-of-range/misaligned fetch fault.

Parameters:
- DEPTH, 40, number of 32-bit words in the instruction memory; legal word index 0..DEPTH-1.
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.

Ports:
- clk  input  1  rising-edge clock, shared with instruction memory
- rst  input  1  synchronous active-high reset
- mem_addr  output  32  word index to memory = fetch_pc >> 2 (zero-extended); purely a function of the fetch_pc register
- mem_rdata  input  32  memory read data; valid the cycle after mem_addr was presented
- out_valid  output  1  queue head holds an instruction
- out_instr  output  32  instruction at queue head
- out_pc  output  32  byte address of out_instr
- out_ready  input  1  decode accepts head; pop = out_valid & out_ready
- redirect_valid  input  1  branch/jump taken; flush and refetch
- redirect_pc  input  32  byte target address
- fault  output  1  sticky: fetch stopped at illegal address
- fault_pc  output  32  the illegal fetch_pc; holds its value while fault=1

Behaviour:
- Reset (rst=1 at a rising edge):
  - fetch_pc=RESET_PC; queue empty; inflight=0; state=RUN.
  - out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0.
  - Reset mid-operation discards all queued and in-flight words.
- FSM states: RUN and FAULT.
  - RUN -> FAULT: at an issue attempt where fetch_pc[1:0]!=0 or (fetch_pc>>2)>=DEPTH. The fetch is not issued; fault=1 and fault_pc=fetch_pc at that edge.
  - FAULT -> RUN: only on redirect_valid or rst.
  - In FAULT: no issue; already-queued entries still drain to decode; an in-flight word is still captured.
- Issue rule (RUN, no redirect, address legal):
  - Issue when count + inflight - pop < 2, where count = queue occupancy 0..2.
  - On issue: fetch_pc += 4 and inflight<=1 (for the read of the current mem_addr); otherwise inflight<=0 and fetch_pc holds.
  - mem_addr is combinationally fetch_pc>>2 every cycle. No combinational path from out_ready to mem_addr.
- Capture: if inflight=1 in cycle N, mem_rdata in cycle N is written to the queue tail with tag pc_inflight (the PC issued in cycle N-1).
  - Push and pop in the same cycle is legal at any occupancy. Count never exceeds 2; exceeding it is a design error and must be assertable.
- Latency: the address issued in cycle N is captured at the end of N+1 and presented with out_valid=1 in N+2.
  - Steady state with out_ready=1 sustains 1 instruction/cycle.
- Stall: out_ready=0 keeps out_valid, out_instr and out_pc stable. Issue halts once count+inflight=2; no word is lost or duplicated.
- Redirect (redirect_valid=1 in cycle N, any state):
  - Queue flushed; inflight cleared, so the word arriving in N+1 is dropped; fault and fault_pc cleared; state=RUN; fetch_pc<=redirect_pc.
  - No issue in cycle N; pop in cycle N is ignored.
  - First issue in N+1; target instruction has out_valid=1 in N+3.
  - Redirect wins over any simultaneous push, pop or fault entry.
- Wrap-around: fetch_pc increments modulo 2^32; the illegal index is caught by the fault check.
- Back-to-back redirects: each one restarts the sequence; only the last target is fetched.

Test Plan:
- Reset release, memory preloaded with word[i]=0x1000_0000+i, out_ready=1 -> out_valid first high 2 cycles after reset; out_pc 0,4,8,... with out_instr 0x1000_0000, 0x1000_0001, ... on consecutive cycles, no gaps.
- Stall: after 3 instructions hold out_ready=0 for 5 cycles -> out_pc holds at 12, mem_addr stops at 5; on release the stream resumes 12,16,20 with no loss or duplicate.
- Redirect: redirect_valid with redirect_pc=0x20 while the queue is full -> queued/in-flight words dropped; next out_valid is 3 cycles later with out_pc=0x20 and out_instr=word[8].
- End of memory: DEPTH=40, run from 0 -> last out_pc=0x9C; fault=1 with fault_pc=0xA0; out_valid stays 0 after drain; redirect to 0 clears fault and restarts fetch.
- Misaligned redirect_pc=0x6 -> no fetch issued; fault=1 with fault_pc=0x6.
- Reset asserted mid-stall with count=2 -> next cycle out_valid=0 and fault=0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/imem_fetch_if.sv
// imem_fetch_if: memory, decode, redirect and fault signals of the fetch sequencer
interface imem_fetch_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;
  modport master (
    output mem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
    input  mem_rdata, out_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  mem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
    output mem_rdata, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch PC sequencer with 2-entry tagged queue, redirect flush and fetch fault
module imem_fetch_ctrl #(
  parameter int          DEPTH    = 40,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  imem_fetch_if.master bus
);
  typedef enum logic {RUN, FAULT} state_t;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  state_t      state, state_n;
  logic [31:0] fetch_pc, pc_inflight, fault_pc_q;
  logic        inflight, hd, valid;
  logic [1:0]  count;
  logic [31:0] q_instr [2];
  logic [31:0] q_pc    [2];
  logic        redir, pop, push, room, legal, attempt, issue;
  assign redir         = bus.redirect_valid;
  assign valid         = count != 2'd0;
  assign bus.mem_addr  = {2'b00, fetch_pc[31:2]};
  assign bus.out_valid = valid;
  assign bus.out_instr = valid ? q_instr[hd] : '0;
  assign bus.out_pc    = valid ? q_pc[hd] : '0;
  assign bus.fault     = state == FAULT;
  assign bus.fault_pc  = fault_pc_q;
  always_comb begin
    pop     = valid & bus.out_ready & ~redir;
    push    = inflight & ~redir;
    // occupancy plus the outstanding read, less what decode takes now, must leave a slot
    room    = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    legal   = fetch_pc[1:0] == 2'b00 && fetch_pc[31:2] < DEPTH_W;
    attempt = state == RUN && !redir && room;
    issue   = attempt && legal;
    state_n = redir ? RUN : (attempt && !legal) ? FAULT : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      pc_inflight <= '0;
      count       <= 2'd0;
      hd          <= 1'b0;
      fault_pc_q  <= '0;
    end else begin
      state       <= state_n;
      inflight    <= issue;
      pc_inflight <= issue ? fetch_pc : pc_inflight;
      fetch_pc    <= redir ? bus.redirect_pc : issue ? fetch_pc + 32'd4 : fetch_pc;
      fault_pc_q  <= redir ? '0 : (attempt && !legal) ? fetch_pc : fault_pc_q;
      count       <= redir ? 2'd0 : count + 2'(push) - 2'(pop);
      hd          <= redir ? 1'b0 : hd ^ pop;
      if (push) begin
        q_instr[hd ^ count[0]] <= bus.mem_rdata;
        q_pc[hd ^ count[0]]    <= pc_inflight;
      end
    end
  end
  assert property (@(posedge clk) disable iff (rst) count != 2'd3 && !(push && !pop && count == 2'd2));
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed checks of stream, stall, redirect, end-of-memory fault and reset
module tb_imem_fetch_ctrl;
  localparam int DEPTH = 40;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  imem_fetch_if bus ();
  imem_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  always @(posedge clk)
    bus.mem_rdata <= (bus.mem_addr < DEPTH) ? 32'h1000_0000 + bus.mem_addr : 32'hDEAD_BEEF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    step();
    step();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
    vectors++; if (bus.out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h want 0", bus.out_instr); end
    vectors++; if (bus.out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want 0", bus.out_pc); end
    vectors++; if (bus.fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %0b want 0", bus.fault); end
    vectors++; if (bus.fault_pc !== 32'h0) begin miscompares++; $display("FAIL reset_fault_pc got %h want 0", bus.fault_pc); end
    vectors++; if (bus.mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_c0_valid got %0b want 0", bus.out_valid); end
    step();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_c1_valid got %0b want 0", bus.out_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * i) || bus.out_instr !== 32'h1000_0000 + 32'(i)) begin
        miscompares++; $display("FAIL stream_%0d got v=%0b pc=%h ins=%h want v=1 pc=%h", i, bus.out_valid, bus.out_pc, bus.out_instr, 4 * i);
      end
    end
  endtask

  task automatic test_stall();
    step();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd12 || bus.out_instr !== 32'h1000_0003 || bus.mem_addr !== 32'd5) begin
        miscompares++; $display("FAIL stall_hold_%0d got v=%0b pc=%h ins=%h addr=%0d want v=1 pc=c ins=10000003 addr=5", k, bus.out_valid, bus.out_pc, bus.out_instr, bus.mem_addr);
      end
      step();
    end
    bus.out_ready = 1'b1;
    for (int i = 3; i < 7; i++) begin
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * i) || bus.out_instr !== 32'h1000_0000 + 32'(i)) begin
        miscompares++; $display("FAIL stall_resume_%0d got v=%0b pc=%h ins=%h want pc=%h", i, bus.out_valid, bus.out_pc, bus.out_instr, 4 * i);
      end
      step();
    end
  endtask

  task automatic test_redirect();
    bus.out_ready = 1'b0;
    step();
    step();
    step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd28) begin miscompares++; $display("FAIL redir_prefull got v=%0b pc=%h want v=1 pc=1c", bus.out_valid, bus.out_pc); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h20;
    bus.out_ready = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0 || bus.mem_addr !== 32'd8) begin miscompares++; $display("FAIL redir_n1 got v=%0b addr=%0d want v=0 addr=8", bus.out_valid, bus.mem_addr); end
    step();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL redir_n2 got v=%0b want 0", bus.out_valid); end
    step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h20 || bus.out_instr !== 32'h1000_0008) begin
      miscompares++; $display("FAIL redir_n3 got v=%0b pc=%h ins=%h want v=1 pc=20 ins=10000008", bus.out_valid, bus.out_pc, bus.out_instr);
    end
    step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h24) begin miscompares++; $display("FAIL redir_n4 got v=%0b pc=%h want pc=24", bus.out_valid, bus.out_pc); end
  endtask

  task automatic test_back_to_back();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect_pc = 32'h10;
    step();
    bus.redirect_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_n2 got v=%0b want 0", bus.out_valid); end
    step();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_n3 got v=%0b pc=%h want v=0", bus.out_valid, bus.out_pc); end
    step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h10 || bus.out_instr !== 32'h1000_0004) begin
      miscompares++; $display("FAIL b2b_n4 got v=%0b pc=%h ins=%h want v=1 pc=10 ins=10000004", bus.out_valid, bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_end_of_memory();
    logic [31:0] exp_pc = 32'h0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    for (int c = 0; c < 120; c++) begin
      step();
      if (bus.out_valid) begin
        vectors++; if (bus.out_pc !== exp_pc || bus.out_instr !== 32'h1000_0000 + (exp_pc >> 2)) begin
          miscompares++; $display("FAIL eom_stream got pc=%h ins=%h want pc=%h", bus.out_pc, bus.out_instr, exp_pc);
        end
        exp_pc += 32'd4;
      end
      if (bus.fault && !bus.out_valid) break;
    end
    vectors++; if (exp_pc !== 32'hA0) begin miscompares++; $display("FAIL eom_last_pc got next=%h want next=a0 (last 9c)", exp_pc); end
    vectors++; if (bus.fault !== 1'b1 || bus.fault_pc !== 32'hA0) begin miscompares++; $display("FAIL eom_fault got f=%0b fpc=%h want f=1 fpc=a0", bus.fault, bus.fault_pc); end
    step();
    step();
    step();
    vectors++; if (bus.out_valid !== 1'b0 || bus.fault !== 1'b1 || bus.fault_pc !== 32'hA0) begin
      miscompares++; $display("FAIL eom_hold got v=%0b f=%0b fpc=%h want v=0 f=1 fpc=a0", bus.out_valid, bus.fault, bus.fault_pc);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0;
    step();
    bus.redirect_valid = 1'b0;
    vectors++; if (bus.fault !== 1'b0 || bus.fault_pc !== 32'h0) begin miscompares++; $display("FAIL eom_clear got f=%0b fpc=%h want f=0 fpc=0", bus.fault, bus.fault_pc); end
    step();
    step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h1000_0000) begin
      miscompares++; $display("FAIL eom_restart got v=%0b pc=%h ins=%h want v=1 pc=0", bus.out_valid, bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_misaligned();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h6;
    step();
    bus.redirect_valid = 1'b0;
    step();
    vectors++; if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h6 || bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL misalign_fault got f=%0b fpc=%h v=%0b want f=1 fpc=6 v=0", bus.fault, bus.fault_pc, bus.out_valid);
    end
    step();
    step();
    vectors++; if (bus.out_valid !== 1'b0 || bus.mem_addr !== 32'd1) begin
      miscompares++; $display("FAIL misalign_idle got v=%0b addr=%0d want v=0 addr=1", bus.out_valid, bus.mem_addr);
    end
  endtask

  task automatic test_reset_mid_stall();
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0;
    step();
    bus.redirect_valid = 1'b0;
    step();
    step();
    step();
    step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin miscompares++; $display("FAIL rstmid_pre got v=%0b pc=%h want v=1 pc=0", bus.out_valid, bus.out_pc); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0 || bus.fault !== 1'b0 || bus.mem_addr !== 32'h0) begin
      miscompares++; $display("FAIL rstmid_clear got v=%0b f=%0b addr=%0d want v=0 f=0 addr=0", bus.out_valid, bus.fault, bus.mem_addr);
    end
    bus.out_ready = 1'b1;
    step();
    step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h1000_0000) begin
      miscompares++; $display("FAIL rstmid_restart got v=%0b pc=%h ins=%h want v=1 pc=0", bus.out_valid, bus.out_pc, bus.out_instr);
    end
    step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4) begin miscompares++; $display("FAIL rstmid_next got v=%0b pc=%h want pc=4", bus.out_valid, bus.out_pc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_end_of_memory();
    test_misaligned();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
